// File: rtl/demux_fifo_router.sv
// Receive side of the 4-lane link: routes each accepted word into a per-lane FIFO.
// Each lane is drained independently through a registered output word.
module demux_fifo_router #(
    parameter int DATA_BITS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enb,
    input  logic [DATA_BITS-1:0] entrada_dmux,
    input  logic [1:0]           selector_dmux,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [3:0]           pop,
    output logic [DATA_BITS-1:0] salida0_dmux,
    output logic [DATA_BITS-1:0] salida1_dmux,
    output logic [DATA_BITS-1:0] salida2_dmux,
    output logic [DATA_BITS-1:0] salida3_dmux,
    output logic [3:0]           empty,
    output logic [3:0]           full,
    output logic                 drop_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] r_mem  [4][FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr [4];
    logic [PTR_W-1:0]     r_rptr [4];
    logic [CNT_W-1:0]     r_cnt  [4];
    logic [DATA_BITS-1:0] r_out  [4];
    logic                 r_drop;

    logic                 w_ready;
    logic [3:0]           w_push;
    logic [3:0]           w_pop;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (r_cnt[i] == '0);
            full[i]  = (r_cnt[i] == CNT_W'(FIFO_DEPTH));
        end
    end

    // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign w_ready   = enb & ~full[selector_dmux];
    assign ready_out = w_ready;

    always_comb begin
        w_push = '0;
        if (valid_in && w_ready) begin
            w_push[selector_dmux] = 1'b1;
        end
        w_pop = {4{enb}} & pop & ~empty;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (w_push[i]) begin
                    r_mem[i][r_wptr[i]] <= entrada_dmux;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
                r_out[i]  <= '0;
            end
            r_drop <= 1'b0;
        end else if (enb) begin
            r_drop <= valid_in & ~w_ready;
            for (int i = 0; i < 4; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PTR_W'(1);
                    r_out[i]  <= r_mem[i][r_rptr[i]];
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end else begin
            r_drop <= 1'b0;
        end
    end

    assign salida0_dmux = r_out[0];
    assign salida1_dmux = r_out[1];
    assign salida2_dmux = r_out[2];
    assign salida3_dmux = r_out[3];
    assign drop_err     = r_drop;

endmodule

// File: tb/tb_demux_fifo_router.sv
// Bench for demux_fifo_router: queue-based lane model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux_fifo_router;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enb;
    logic [DB-1:0] entrada_dmux;
    logic [1:0]    selector_dmux;
    logic          valid_in;
    logic          ready_out;
    logic [3:0]    pop;
    logic [DB-1:0] salida0_dmux, salida1_dmux, salida2_dmux, salida3_dmux;
    logic [3:0]    empty;
    logic [3:0]    full;
    logic          drop_err;

    demux_fifo_router #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enb(enb),
        .entrada_dmux(entrada_dmux), .selector_dmux(selector_dmux),
        .valid_in(valid_in), .ready_out(ready_out), .pop(pop),
        .salida0_dmux(salida0_dmux), .salida1_dmux(salida1_dmux),
        .salida2_dmux(salida2_dmux), .salida3_dmux(salida3_dmux),
        .empty(empty), .full(full), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DB-1:0] mq [4][$];
    logic [DB-1:0] m_out [4];
    logic          m_drop = 1'b0;
    logic          m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DB-1:0] dut_out(input int i);
        case (i)
            0: return salida0_dmux;
            1: return salida1_dmux;
            2: return salida2_dmux;
            default: return salida3_dmux;
        endcase
    endfunction

    task automatic compare_all();
        logic [3:0] e_empty, e_full;
        for (int i = 0; i < 4; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == DEPTH);
            chk($sformatf("salida%0d", i), 32'(dut_out(i)), 32'(m_out[i]));
        end
        chk("empty", 32'(empty), 32'(e_empty));
        chk("full", 32'(full), 32'(e_full));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
    endtask

    // One clock: inputs applied at negedge, model stepped, outputs checked at next negedge.
    task automatic cycle(input logic r, input logic e, input logic v,
                         input logic [1:0] sel, input logic [DB-1:0] d, input logic [3:0] p);
        logic full_pre;
        reset = r; enb = e; valid_in = v; selector_dmux = sel; entrada_dmux = d; pop = p;
        #1;
        if (m_valid) begin
            chk("ready_out", 32'(ready_out), 32'(e && (mq[sel].size() != DEPTH)));
        end
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                m_out[i] = '0;
            end
            m_drop  = 1'b0;
            m_valid = 1'b1;
        end else if (e) begin
            full_pre = (mq[sel].size() == DEPTH);
            m_drop = v && full_pre;
            for (int i = 0; i < 4; i++) begin
                if (p[i] && mq[i].size() > 0) m_out[i] = mq[i].pop_front();
            end
            if (v && !full_pre) mq[sel].push_back(d);
        end else begin
            m_drop = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (m_valid) compare_all();
    endtask

    initial begin
        reset = 1'b1; enb = 1'b0; valid_in = 1'b0; selector_dmux = '0;
        entrada_dmux = '0; pop = '0;
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        @(negedge clk);

        // Reset then idle
        cycle(1, 1, 0, 0, 0, 4'b0000);
        cycle(0, 1, 0, 0, 0, 4'b0000);
        chk("t1_empty", 32'(empty), 32'h0000000f);
        chk("t1_full", 32'(full), 32'h0);
        chk("t1_ready", 32'(ready_out), 32'h1);
        chk("t1_drop", 32'(drop_err), 32'h0);

        // Routing
        cycle(0, 1, 1, 3, 4'b1110, 4'b0000);
        cycle(0, 1, 1, 2, 4'b1100, 4'b0000);
        cycle(0, 1, 1, 1, 4'b1010, 4'b0000);
        cycle(0, 1, 1, 0, 4'b0010, 4'b0000);
        cycle(0, 1, 0, 0, 0, 4'b1111);
        chk("t2_s0", 32'(salida0_dmux), 32'b0010);
        chk("t2_s1", 32'(salida1_dmux), 32'b1010);
        chk("t2_s2", 32'(salida2_dmux), 32'b1100);
        chk("t2_s3", 32'(salida3_dmux), 32'b1110);
        chk("t2_empty", 32'(empty), 32'h0000000f);

        // Full lane and backpressure
        for (int k = 1; k <= 4; k++) cycle(0, 1, 1, 1, DB'(k), 4'b0000);
        chk("t3_full1", 32'(full[1]), 32'h1);
        chk("t3_ready", 32'(ready_out), 32'h0);
        cycle(0, 1, 1, 1, 4'd5, 4'b0000);
        chk("t3_drop", 32'(drop_err), 32'h1);
        cycle(0, 1, 0, 1, 0, 4'b0000);
        chk("t3_drop_clr", 32'(drop_err), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 1, 0, 0, 0, 4'b0010);
            chk("t3_pop", 32'(salida1_dmux), 32'(k));
        end
        cycle(0, 1, 0, 0, 0, 4'b0010);
        chk("t3_no5", 32'(salida1_dmux), 32'h4);

        // Push and pop together on lane 0
        cycle(0, 1, 1, 0, 4'h9, 4'b0001);
        chk("t4_hold", 32'(salida0_dmux), 32'b0010);
        chk("t4_nonempty", 32'(empty[0]), 32'h0);
        cycle(0, 1, 1, 0, 4'hA, 4'b0001);
        chk("t4_s0", 32'(salida0_dmux), 32'h9);
        chk("t4_cnt1", 32'(empty[0]), 32'h0);
        cycle(0, 1, 0, 0, 0, 4'b0001);
        chk("t4_drain", 32'(salida0_dmux), 32'hA);

        // Wrap-around on lane 2
        cycle(0, 1, 1, 2, 4'd0, 4'b0000);
        cycle(0, 1, 1, 2, 4'd1, 4'b0000);
        for (int k = 2; k <= 9; k++) begin
            cycle(0, 1, 1, 2, DB'(k), 4'b0100);
            chk("t5_pop", 32'(salida2_dmux), 32'(k - 2));
            chk("t5_notfull", 32'(full[2]), 32'h0);
        end
        cycle(0, 1, 0, 0, 0, 4'b0100);
        chk("t5_pop8", 32'(salida2_dmux), 32'h8);
        cycle(0, 1, 0, 0, 0, 4'b0100);
        chk("t5_pop9", 32'(salida2_dmux), 32'h9);

        // enb low, then reset mid-operation
        cycle(0, 1, 1, 3, 4'h6, 4'b0000);
        cycle(0, 1, 1, 3, 4'h7, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 3, 4'hF, 4'b1000);
            chk("t6_ready", 32'(ready_out), 32'h0);
            chk("t6_drop", 32'(drop_err), 32'h0);
            chk("t6_held", 32'(salida3_dmux), 32'b1110);
        end
        cycle(1, 0, 1, 3, 4'hF, 4'b1000);
        chk("t6_empty3", 32'(empty[3]), 32'h1);
        chk("t6_s3", 32'(salida3_dmux), 32'h0);
        cycle(0, 1, 0, 0, 0, 4'b1000);
        chk("t6_s3_after", 32'(salida3_dmux), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  DB'($urandom),
                  4'($urandom) & 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
